fetch_queue_unit: RTL and testbench

Parametrised instruction-fetch stage for the pipelined RISC-V core. It replaces the single-register IF latch with a DEPTH-entry prefetch queue and a request/response instruction-memory port that can keep several fetches in flight. It feeds the decode stage through a valid/ready handshake. Branch/jump redirects flush the queue and discard stale in-flight responses. A fetched all-zero word stops further fetching until the next redirect.

---
 rtl/rv_pipe_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 50 +++++
 rtl/fetch_queue_unit.sv | 109 ++++++++++
 tb/tb_fetch_queue_unit.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared pipeline constants and the fetch queue entry type
package rv_pipe_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST  = 32'h0000_0013;
    localparam logic [XLEN-1:0] ZERO_INST = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry FIFO with flush, occupancy count and same-edge push/pop
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic [W-1:0]            push_data_i,
    input  logic                    pop_i,
    output logic [W-1:0]            head_o,
    output logic [$clog2(DEPTH):0]  count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // When full, a push lands on the head slot; the head is read before the edge so a same-edge pop is safe.
    always_ff @(negedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign count_o = wr_ptr_q - rd_ptr_q;
endmodule

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - prefetching IF stage with credit-limited in-flight fetches and redirect flush
module fetch_queue_unit #(
    parameter int              XLEN     = rv_pipe_pkg::XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            fetch_stopped
);
    import rv_pipe_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]     DEPTH_W    = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] ZERO_WORD  = XLEN'(ZERO_INST);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(3);

    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic              stopped_q, stopped_d;
    logic [AW:0]       fifo_count;
    logic [2*XLEN-1:0] fifo_head;
    logic              empty, credit_ok, accept, rsp_drop, push, pop, zero_word;

    assign empty     = (fifo_count == '0);
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < DEPTH_W;

    assign imem_req_valid = rst & ~halt & ~stopped_q & ~redirect_valid & credit_ok;
    assign imem_addr      = fetch_pc_q;
    assign accept         = imem_req_valid & imem_req_ready;

    assign rsp_drop  = (drop_q != '0);
    assign push      = imem_rsp_valid & ~rsp_drop & ~redirect_valid;
    assign zero_word = push & (imem_rsp_data == ZERO_WORD);

    assign id_valid      = ~empty & ~halt;
    assign pop           = id_valid & id_ready & ~redirect_valid;
    assign id_pc         = empty ? '0 : fifo_head[2*XLEN-1:XLEN];
    assign id_inst       = empty ? '0 : fifo_head[XLEN-1:0];
    assign fetch_stopped = stopped_q;

    always_comb begin
        outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rsp_valid);
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_d        = drop_q;
        stopped_d     = stopped_q;
        if (redirect_valid) begin
            // Everything still in flight belongs to the old path and must be skipped.
            fetch_pc_d = redirect_pc & ~ALIGN_MASK;
            rsp_pc_d   = redirect_pc & ~ALIGN_MASK;
            drop_d     = outstanding_d;
            stopped_d  = 1'b0;
        end else begin
            if (accept)                    fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (imem_rsp_valid && rsp_drop) drop_d    = drop_q - 1'b1;
            if (push)                      rsp_pc_d   = rsp_pc_q + XLEN'(4);
            if (zero_word) begin
                stopped_d = 1'b1;
                drop_d    = outstanding_d;
            end
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            stopped_q     <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            stopped_q     <= stopped_d;
        end
    end

    fetch_fifo #(
        .W     (2*XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i ({rsp_pc_q, imem_rsp_data}),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - randomized self-checking bench for fetch_queue_unit
module tb_fetch_queue_unit;
    import rv_pipe_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk, rst;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_addr, imem_rsp_data;
    logic        id_valid, id_ready, redirect_valid, halt, fetch_stopped;
    logic [31:0] id_inst, id_pc, redirect_pc;

    fetch_queue_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .fetch_stopped(fetch_stopped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    bit          d_halt, d_idr, d_redir;
    logic [31:0] d_rpc;
    int          ready_pct, rsp_pct;
    bit          zero_en;
    logic [31:0] zero_pc;

    fetch_entry_t mq[$];
    logic [31:0]  memq[$];
    int           m_out, m_drop;
    logic [31:0]  m_fpc, m_rpc, m_last_pop;
    bit           m_stop;

    logic [98:0] obs_vec, exp_vec;
    logic        obs_rv, obs_iv, obs_st;
    logic [31:0] obs_addr, obs_pc, obs_inst;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (zero_en && a == zero_pc) ? 32'h0 : a + 32'h100;
    endfunction

    task automatic model_reset();
        mq.delete();
        memq.delete();
        m_out = 0; m_drop = 0; m_stop = 0;
        m_fpc = RESET_PC; m_rpc = RESET_PC; m_last_pop = RESET_PC - 32'd4;
    endtask

    // One clock: drive at posedge, sample 1 time unit later, then advance the model across the next falling edge.
    task automatic cycle();
        bit exp_rv, exp_iv, acc, pop;
        logic [31:0] exp_inst, exp_pc;
        fetch_entry_t e;
        @(posedge clk);
        halt = d_halt; id_ready = d_idr; redirect_valid = d_redir; redirect_pc = d_rpc;
        imem_req_ready = ($urandom_range(99) < 32'(ready_pct));
        if (memq.size() > 0 && $urandom_range(99) < 32'(rsp_pct)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(memq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        obs_rv = imem_req_valid; obs_addr = imem_addr; obs_iv = id_valid;
        obs_inst = id_inst; obs_pc = id_pc; obs_st = fetch_stopped;
        obs_vec = {obs_rv, obs_addr, obs_iv, obs_inst, obs_pc, obs_st};
        exp_rv   = !halt && !m_stop && !redirect_valid && (mq.size() + m_out < DEPTH);
        exp_iv   = (mq.size() > 0) && !halt;
        exp_inst = (mq.size() > 0) ? mq[0].inst : 32'h0;
        exp_pc   = (mq.size() > 0) ? mq[0].pc   : 32'h0;
        exp_vec  = {exp_rv, m_fpc, exp_iv, exp_inst, exp_pc, m_stop};
        if (obs_rv && imem_req_ready) memq.push_back(obs_addr);
        acc = exp_rv && imem_req_ready;
        pop = exp_iv && id_ready && !redirect_valid;
        if (redirect_valid) begin
            mq.delete();
            m_out  = m_out - int'(imem_rsp_valid);
            m_drop = m_out;
            m_fpc  = {redirect_pc[31:2], 2'b00};
            m_rpc  = m_fpc;
            m_stop = 0;
        end else begin
            if (pop) begin
                m_last_pop = mq[0].pc;
                void'(mq.pop_front());
            end
            m_out = m_out + int'(acc) - int'(imem_rsp_valid);
            if (acc) m_fpc = m_fpc + 32'd4;
            if (imem_rsp_valid) begin
                if (m_drop > 0) m_drop--;
                else begin
                    e.pc = m_rpc; e.inst = imem_rsp_data;
                    mq.push_back(e);
                    m_rpc = m_rpc + 32'd4;
                    if (imem_rsp_data == 32'h0) begin
                        m_stop = 1;
                        m_drop = m_out;
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {halt, id_ready, redirect_valid, imem_req_ready, imem_rsp_valid} = '0;
        redirect_pc = '0; imem_rsp_data = '0;
        d_halt = 0; d_idr = 1; d_redir = 0; d_rpc = '0;
        ready_pct = 100; rsp_pct = 100; zero_en = 0; zero_pc = '0;
        #1 rst = 1'b0;
        #2;
        n_cmp++;
        if ({imem_req_valid, id_valid, id_inst, id_pc, fetch_stopped} !== 67'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got rv=%b iv=%b inst=%h pc=%h st=%b want all zero",
                     imem_req_valid, id_valid, id_inst, id_pc, fetch_stopped);
        end
        model_reset();
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 24; i++) begin
            cycle();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++; $display("FAIL stream_model cyc%0d got %h want %h", i, obs_vec, exp_vec);
            end
            if (i >= 2) begin
                n_cmp++;
                if (!obs_iv || obs_pc !== 32'(4*(i-2)) || obs_inst !== 32'(4*(i-2)) + 32'h100) begin
                    n_fail++;
                    $display("FAIL stream_seq cyc%0d got iv=%b pc=%h inst=%h want pc=%h", i, obs_iv, obs_pc, obs_inst, 4*(i-2));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] p;
        p = m_last_pop + 32'd4;
        d_idr = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++; $display("FAIL stall_model cyc%0d got %h want %h", i, obs_vec, exp_vec);
            end
        end
        n_cmp++;
        if ({obs_rv, obs_iv} !== 2'b01) begin
            n_fail++; $display("FAIL stall_full got rv=%b iv=%b want rv=0 iv=1", obs_rv, obs_iv);
        end
        d_idr = 1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            n_cmp++;
            if (!obs_iv || obs_pc !== p + 32'(4*k) || obs_inst !== p + 32'(4*k) + 32'h100) begin
                n_fail++;
                $display("FAIL stall_release k%0d got iv=%b pc=%h inst=%h want pc=%h", k, obs_iv, obs_pc, obs_inst, p + 32'(4*k));
            end
        end
    endtask

    task automatic wait_valid(input string name, input logic [31:0] want_pc);
        bit seen = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++; $display("FAIL %s_model got %h want %h", name, obs_vec, exp_vec);
            end
            if (obs_iv) begin seen = 1; break; end
        end
        n_cmp++;
        if (!seen || obs_pc !== want_pc || obs_inst !== mem_word(want_pc)) begin
            n_fail++;
            $display("FAIL %s got iv=%b pc=%h inst=%h want pc=%h inst=%h", name, obs_iv, obs_pc, obs_inst, want_pc, mem_word(want_pc));
        end
    endtask

    task automatic hold_inflight(input int n);
        rsp_pct = 0;
        for (int k = 0; k < 20 && m_out < n; k++) begin
            cycle();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++; $display("FAIL inflight_model got %h want %h", obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_redirect();
        hold_inflight(2);
        rsp_pct = 100; d_redir = 1; d_rpc = 32'h80;
        cycle();
        d_redir = 0;
        wait_valid("redirect_first", 32'h80);
        wait_valid("redirect_second", 32'h84);
        d_redir = 1; d_rpc = 32'h83;
        cycle();
        d_redir = 0;
        cycle();
        n_cmp++;
        if (obs_addr !== 32'h80) begin
            n_fail++; $display("FAIL redirect_align got addr=%h want 00000080", obs_addr);
        end
    endtask

    task automatic test_zero_stop();
        bit seen = 0;
        zero_en = 1; zero_pc = 32'h10;
        d_redir = 1; d_rpc = 32'h0;
        cycle();
        d_redir = 0;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (obs_iv && obs_pc == 32'h10) begin seen = 1; break; end
        end
        n_cmp++;
        if (!seen || obs_inst !== 32'h0 || obs_st !== 1'b1) begin
            n_fail++; $display("FAIL zero_deliver got seen=%b inst=%h st=%b want inst=0 st=1", seen, obs_inst, obs_st);
        end
        for (int k = 0; k < 5; k++) begin
            cycle();
            n_cmp++;
            if ({obs_rv, obs_st} !== 2'b01 || obs_vec !== exp_vec) begin
                n_fail++; $display("FAIL zero_parked k%0d got rv=%b st=%b vec=%h want rv=0 st=1 vec=%h", k, obs_rv, obs_st, obs_vec, exp_vec);
            end
        end
        d_redir = 1; d_rpc = 32'h20;
        cycle();
        d_redir = 0;
        zero_en = 0;
        cycle();
        n_cmp++;
        if (obs_st !== 1'b0 || obs_rv !== 1'b1) begin
            n_fail++; $display("FAIL zero_resume got st=%b rv=%b want st=0 rv=1", obs_st, obs_rv);
        end
        wait_valid("zero_resume_pc", 32'h20);
    endtask

    task automatic test_halt();
        logic [31:0] nxt;
        hold_inflight(2);
        nxt = m_last_pop + 32'd4;
        rsp_pct = 100; d_halt = 1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            n_cmp++;
            if ({obs_iv, obs_rv} !== 2'b00 || obs_vec !== exp_vec) begin
                n_fail++; $display("FAIL halt_hold k%0d got iv=%b rv=%b vec=%h want iv=0 rv=0 vec=%h", k, obs_iv, obs_rv, obs_vec, exp_vec);
            end
        end
        d_halt = 0;
        wait_valid("halt_release", nxt);
    endtask

    task automatic test_mid_reset();
        int lat = -1;
        hold_inflight(3);
        rsp_pct = 100;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({imem_req_valid, id_valid, id_inst, id_pc, fetch_stopped} !== 67'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs got rv=%b iv=%b inst=%h pc=%h st=%b want all zero",
                     imem_req_valid, id_valid, id_inst, id_pc, fetch_stopped);
        end
        model_reset();
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++; $display("FAIL midreset_model k%0d got %h want %h", k, obs_vec, exp_vec);
            end
            if (obs_iv) begin lat = k; break; end
        end
        n_cmp++;
        if (lat != 2 || obs_pc !== RESET_PC) begin
            n_fail++; $display("FAIL midreset_first got latency=%0d pc=%h want latency=2 pc=%h", lat, obs_pc, RESET_PC);
        end
    endtask

    task automatic test_random();
        zero_en = 1; zero_pc = 32'h40;
        ready_pct = 70; rsp_pct = 60;
        for (int i = 0; i < 400; i++) begin
            d_halt  = ($urandom_range(9) == 0);
            d_idr   = ($urandom_range(9) < 7);
            d_redir = ($urandom_range(19) == 0);
            d_rpc   = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h1FF);
            cycle();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++; $display("FAIL random_model cyc%0d got %h want %h", i, obs_vec, exp_vec);
            end
        end
        d_halt = 0; d_redir = 0; d_idr = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_zero_stop();
        test_halt();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
